// File: rtl/sum_drain.sv
// Sum RAM readout: bias, round-shift and saturate partial sums onto a stream.
// Define SUM_DRAIN_RELU_EN to clamp negative results to zero.
module sum_drain #(
    parameter int C_DSIZE  = 24,
    parameter int C_ASIZE  = 10,
    parameter int C_OSIZE  = 8,
    parameter int C_SHW    = 5,
    parameter int C_RD_LAT = 3
) (
    input  logic               I_clk,
    input  logic               I_rst_n,
    input  logic               I_start,
    input  logic [C_ASIZE:0]   I_len,
    input  logic [C_DSIZE-1:0] I_bias,
    input  logic [C_SHW-1:0]   I_shift,
    output logic [C_ASIZE-1:0] O_raddr,
    input  logic [C_DSIZE-1:0] I_rdata,
    output logic [C_OSIZE-1:0] O_dout,
    output logic               O_dv,
    input  logic               I_rdy,
    output logic               O_busy,
    output logic               O_done
);

    localparam int PIPE = C_RD_LAT + 2;
    localparam int CRED = C_RD_LAT + 3;
    localparam int MDEP = CRED - 1;
    localparam int PW   = (MDEP > 1) ? $clog2(MDEP) : 1;
    localparam int CW   = $clog2(2 * CRED);
    localparam int TW   = C_DSIZE + 2;

    localparam logic signed [TW-1:0] OMAX = TW'(2 ** (C_OSIZE - 1) - 1);
    localparam logic signed [TW-1:0] OMIN = ~OMAX;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FLUSH,
        S_DONE
    } state_t;

    state_t state_q, state_d;
    logic busy_q, busy_d;
    logic done_q, done_d;
    logic [C_ASIZE:0] len_q, len_d;
    logic [C_ASIZE:0] icnt_q, icnt_d;
    logic [C_DSIZE-1:0] bias_q, bias_d;
    logic [C_SHW-1:0] shift_q, shift_d;
    logic [C_ASIZE-1:0] raddr_q, raddr_d;
    logic [PIPE-1:0] vld_q, vld_d;
    logic signed [TW-1:0] sa_q, sa_d;
    logic signed [C_OSIZE-1:0] sb_q, sb_d;
    logic [C_OSIZE-1:0] dout_q, dout_d;
    logic dv_q, dv_d;
    logic [CW-1:0] mcnt_q, mcnt_d;
    logic [PW-1:0] rd_q, rd_d;
    logic [PW-1:0] wr_q, wr_d;
    logic [C_OSIZE-1:0] mem_q [MDEP];

    logic pop, push, issue, out_free, mem_we;
    logic [CW-1:0] infl, occ;
    logic signed [TW-1:0] rnd, y_b;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(MDEP - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        infl = '0;
        for (int i = 0; i < PIPE; i++) begin
            infl = infl + CW'(vld_q[i]);
        end
    end

    // Credits: a popped word frees its slot in the same cycle.
    assign pop   = dv_q & I_rdy;
    assign push  = vld_q[PIPE-1];
    assign occ   = infl + mcnt_q + CW'(dv_q) - CW'(pop);
    assign issue = (state_q == S_RUN) && (occ < CW'(CRED));

    always_comb begin
        rnd = '0;
        if (shift_q != '0 && int'(shift_q) <= C_DSIZE) begin
            rnd = TW'(1) << (shift_q - 1'b1);
        end
        sa_d = {{2{I_rdata[C_DSIZE-1]}}, I_rdata}
             + {{2{bias_q[C_DSIZE-1]}}, bias_q}
             + rnd;
    end

    always_comb begin
        y_b = sa_q >>> shift_q;
`ifdef SUM_DRAIN_RELU_EN
        if (y_b < 0) begin
            y_b = '0;
        end
`endif
        if (y_b > OMAX) begin
            sb_d = OMAX[C_OSIZE-1:0];
        end else if (y_b < OMIN) begin
            sb_d = OMIN[C_OSIZE-1:0];
        end else begin
            sb_d = y_b[C_OSIZE-1:0];
        end
    end

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        bias_d  = bias_q;
        shift_d = shift_q;
        raddr_d = raddr_q;
        icnt_d  = icnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (I_start) begin
                    len_d   = I_len;
                    bias_d  = I_bias;
                    shift_d = I_shift;
                    raddr_d = '0;
                    icnt_d  = '0;
                    state_d = (I_len == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (issue) begin
                    raddr_d = raddr_q + 1'b1;
                    icnt_d  = icnt_q + 1'b1;
                    if (icnt_q + 1'b1 == len_q) begin
                        state_d = S_FLUSH;
                    end
                end
            end
            S_FLUSH: begin
                if (infl == '0 && mcnt_q == '0 && (!dv_q || pop)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d == S_RUN) || (state_d == S_FLUSH);
        done_d = (state_d == S_DONE);
        vld_d  = {vld_q[PIPE-2:0], issue};
    end

    // Output register is the FIFO head; mem_q holds the words behind it.
    always_comb begin
        dout_d   = dout_q;
        dv_d     = dv_q;
        mcnt_d   = mcnt_q;
        rd_d     = rd_q;
        wr_d     = wr_q;
        mem_we   = 1'b0;
        out_free = !dv_q || pop;
        if (out_free) begin
            if (mcnt_q != '0) begin
                dout_d = mem_q[rd_q];
                dv_d   = 1'b1;
                rd_d   = nxt(rd_q);
                mcnt_d = mcnt_q - 1'b1;
            end else if (push) begin
                dout_d = sb_q;
                dv_d   = 1'b1;
            end else begin
                dv_d = 1'b0;
            end
        end
        if (push && !(out_free && mcnt_q == '0)) begin
            mem_we = 1'b1;
            wr_d   = nxt(wr_q);
            mcnt_d = mcnt_d + 1'b1;
        end
    end

    always_ff @(posedge I_clk) begin
        if (mem_we) begin
            mem_q[wr_q] <= sb_q;
        end
    end

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            len_q   <= '0;
            icnt_q  <= '0;
            bias_q  <= '0;
            shift_q <= '0;
            raddr_q <= '0;
            vld_q   <= '0;
            sa_q    <= '0;
            sb_q    <= '0;
            dout_q  <= '0;
            dv_q    <= 1'b0;
            mcnt_q  <= '0;
            rd_q    <= '0;
            wr_q    <= '0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            len_q   <= len_d;
            icnt_q  <= icnt_d;
            bias_q  <= bias_d;
            shift_q <= shift_d;
            raddr_q <= raddr_d;
            vld_q   <= vld_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            dout_q  <= dout_d;
            dv_q    <= dv_d;
            mcnt_q  <= mcnt_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
        end
    end

    assign O_raddr = raddr_q;
    assign O_dout  = dout_q;
    assign O_dv    = dv_q;
    assign O_busy  = busy_q;
    assign O_done  = done_q;

endmodule

// File: tb/tb_sum_drain.sv
// Directed bench for sum_drain with a 3-cycle behavioural sum RAM.
`timescale 1ns/1ps
module tb_sum_drain;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [10:0] len = '0;
    logic [23:0] bias = '0;
    logic [4:0]  shift = '0;
    logic [9:0]  raddr;
    logic [23:0] rdata;
    logic [7:0]  dout;
    logic        dv;
    logic        rdy = 1'b1;
    logic        busy;
    logic        done;

    always #5 clk = ~clk;

    sum_drain dut (
        .I_clk   (clk),
        .I_rst_n (rst_n),
        .I_start (start),
        .I_len   (len),
        .I_bias  (bias),
        .I_shift (shift),
        .O_raddr (raddr),
        .I_rdata (rdata),
        .O_dout  (dout),
        .O_dv    (dv),
        .I_rdy   (rdy),
        .O_busy  (busy),
        .O_done  (done)
    );

    logic [23:0] ram [1024];
    logic [23:0] p0, p1, p2;
    always @(posedge clk) begin
        p0 <= ram[raddr];
        p1 <= p0;
        p2 <= p1;
    end
    assign rdata = p2;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int t0 = 0;
    int done_cyc;
    int issued, xfers, max_out;
    logic [9:0] last_raddr;
    logic [9:0] raddr1;
    logic busy1;
    logic raddr_nz;
    logic hold_v = 1'b0;
    logic [7:0] hold_d;
    logic [7:0] rx_q[$];
    int rx_cyc[$];

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] exp_v(input int v);
`ifdef SUM_DRAIN_RELU_EN
        if (v < 0) return 8'h00;
`endif
        return 8'(v);
    endfunction

    function automatic int pat(input int i);
        return 100 - (i % 200);
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst_n) begin
            hold_v = 1'b0;
        end else begin
            if (raddr != last_raddr) issued++;
            last_raddr = raddr;
            if (issued - xfers > max_out) max_out = issued - xfers;
            if (hold_v) chk("hold", {23'd0, dv, dout}, {23'd0, 1'b1, hold_d});
            hold_v = dv && !rdy;
            hold_d = dout;
            if (dv && rdy) begin
                rx_q.push_back(dout);
                rx_cyc.push_back(cyc - t0);
                xfers++;
            end
        end
    end

    task automatic run(input int n, input int b, input int s, input bit rr,
                       input int restart_at, input int stop_rx,
                       input int budget);
        rx_q.delete();
        rx_cyc.delete();
        done_cyc = -1;
        raddr_nz = 1'b0;
        len = 11'(n);
        bias = 24'(b);
        shift = 5'(s);
        start = 1'b1;
        t0 = cyc;
        @(posedge clk); #1;
        start = 1'b0;
        len = '0;
        bias = '0;
        shift = '0;
        busy1 = busy;
        raddr1 = raddr;
        issued = 0;
        xfers = 0;
        max_out = 0;
        last_raddr = raddr;
        if (done) done_cyc = cyc - t0;
        for (int i = 0; i < budget && done_cyc < 0; i++) begin
            @(posedge clk); #1;
            rdy = rr ? ($urandom_range(0, 9) < 3) : 1'b1;
            start = ((cyc - t0) == restart_at);
            len = start ? 11'd5 : 11'd0;
            if (raddr != '0) raddr_nz = 1'b1;
            if (done) done_cyc = cyc - t0;
            if (stop_rx > 0 && rx_q.size() >= stop_rx) break;
        end
        start = 1'b0;
        len = '0;
        rdy = 1'b1;
        if (stop_rx == 0) chk("done_seen", {31'd0, done}, 32'd1);
    endtask

    task automatic check_seq(input string tag, input int n);
        int bad = 0;
        for (int i = 0; i < rx_q.size() && i < n; i++) begin
            if (rx_q[i] !== exp_v(pat(i))) bad++;
        end
        chk({tag, "_cnt"}, rx_q.size(), n);
        chk({tag, "_data"}, bad, 0);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) ram[i] = '0;
        #12;
        chk("rst_dout", {24'd0, dout}, 0);
        chk("rst_dv", {31'd0, dv}, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_done", {31'd0, done}, 0);
        chk("rst_raddr", {22'd0, raddr}, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        ram[0] = 24'd5;
        ram[1] = -24'sd3;
        ram[2] = 24'd127;
        ram[3] = -24'sd128;
        run(4, 0, 0, 1'b0, -1, 0, 100);
        chk("basic_busy1", {31'd0, busy1}, 1);
        chk("basic_raddr1", {22'd0, raddr1}, 0);
        chk("basic_cnt", rx_q.size(), 4);
        chk("basic_d0", {24'd0, rx_q[0]}, {24'd0, exp_v(5)});
        chk("basic_d1", {24'd0, rx_q[1]}, {24'd0, exp_v(-3)});
        chk("basic_d2", {24'd0, rx_q[2]}, {24'd0, exp_v(127)});
        chk("basic_d3", {24'd0, rx_q[3]}, {24'd0, exp_v(-128)});
        chk("basic_first", rx_cyc[0], 7);
        chk("basic_last", rx_cyc[3], 10);
        chk("basic_done", done_cyc, 11);
        @(posedge clk); #1;

        ram[0] = 24'h000008;
        ram[1] = 24'h7FFFFF;
        ram[2] = 24'hFFF000;
        run(3, 100, 4, 1'b0, -1, 0, 100);
        chk("rnd_cnt", rx_q.size(), 3);
        chk("rnd_d0", {24'd0, rx_q[0]}, 32'd7);
        chk("rnd_d1", {24'd0, rx_q[1]}, 32'd127);
`ifdef SUM_DRAIN_RELU_EN
        chk("rnd_d2", {24'd0, rx_q[2]}, 32'h00);
`else
        chk("rnd_d2", {24'd0, rx_q[2]}, 32'h80);
`endif
        chk("rnd_first", rx_cyc[0], 7);
        @(posedge clk); #1;

        run(0, 0, 0, 1'b0, -1, 0, 20);
        chk("l0_done", done_cyc, 1);
        chk("l0_busy", {31'd0, busy1}, 0);
        chk("l0_cnt", rx_q.size(), 0);
        chk("l0_raddr", {21'd0, raddr_nz, raddr1}, 0);
        @(posedge clk); #1;

        for (int i = 0; i < 1024; i++) ram[i] = 24'(pat(i));
        run(16, 0, 0, 1'b1, -1, 0, 2000);
        check_seq("bp", 16);
        chk("bp_outstanding", {31'd0, max_out <= 6}, 1);
        @(posedge clk); #1;

        run(1024, 0, 0, 1'b0, 100, 0, 3000);
        check_seq("full", 1024);
        chk("full_issued", issued, 1024);
        chk("full_wrap", {22'd0, raddr}, 0);
        chk("full_done", done_cyc, 1031);
        @(posedge clk); #1;

        run(16, 0, 0, 1'b0, -1, 10, 200);
        chk("mid_cnt", rx_q.size(), 10);
        rst_n = 1'b0;
        #1;
        chk("mid_dout", {24'd0, dout}, 0);
        chk("mid_dv", {31'd0, dv}, 0);
        chk("mid_busy", {31'd0, busy}, 0);
        chk("mid_done", {31'd0, done}, 0);
        chk("mid_raddr", {22'd0, raddr}, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run(4, 0, 0, 1'b0, -1, 0, 100);
        check_seq("replay", 4);
        chk("replay_first", rx_cyc[0], 7);
        @(posedge clk); #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sum_drain.md
# sum_drain

Readout stage directly downstream of the accumulating ping-pong sum RAM. After the final accumulation pass, it sweeps the read port of the finished bank with linear addresses. Each 24-bit partial sum is bias-added, round-shifted and saturated to an 8-bit activation. Results go out on a valid/ready stream toward the output buffer writer. A credit-based skid FIFO absorbs the RAM's fixed read latency so that downstream back-pressure never drops data.

## Interface
- C_DSIZE, 24, width of accumulated sum and bias (signed)
- C_ASIZE, 10, sum RAM address width
- C_OSIZE, 8, output activation width (signed)
- C_SHW, 5, width of the shift amount
- C_RD_LAT, 3, cycles from O_raddr driven to I_rdata valid (sum RAM read path)

Ports:
- I_clk  in  1  single clock
- I_rst_n  in  1  reset, asynchronous assert, active-low
- I_start  in  1  one-cycle start pulse; ignored unless idle
- I_len  in  C_ASIZE+1  word count, 0..2^C_ASIZE; latched on start
- I_bias  in  C_DSIZE  signed bias; latched on start
- I_shift  in  C_SHW  right-shift amount; latched on start
- O_raddr  out  C_ASIZE  read address to the sum RAM (its I_raddr; its I_dven must be low while busy)
- I_rdata  in  C_DSIZE  sum RAM read data
- O_dout  out  C_OSIZE  requantized result
- O_dv  out  1  O_dout valid
- I_rdy  in  1  downstream ready; transfer when O_dv && I_rdy
- O_busy  out  1  high from the cycle after start until done
- O_done  out  1  one-cycle pulse after the last transfer

## Operation
- FSM states and transitions:
  - IDLE -> RUN on I_start with I_len!=0.
  - IDLE -> DONE on I_start with I_len==0.
  - RUN -> FLUSH once I_len reads have been issued.
  - FLUSH -> DONE when in-flight count is 0 and the FIFO is empty.
  - DONE -> IDLE unconditionally. O_done=1 only in DONE.
- Issue rule: a read issues in RUN when inflight + fifo_cnt < C_RD_LAT+3.
  - On issue, O_raddr increments after being presented. It starts at 0.
  - O_raddr holds its value when no read issues.
- The in-flight valid shift register has length C_RD_LAT+2: RAM latency plus two arithmetic stages.
- Arithmetic:
  - Stage A: t = sext(I_rdata) + sext(bias) + (s>0 ? 2^(s-1) : 0), computed at C_DSIZE+2 bits.
  - Stage B: y = t >>> s (arithmetic), then saturated to [-2^(C_OSIZE-1), 2^(C_OSIZE-1)-1].
  - Shift amounts s ≥ C_DSIZE+1 give 0 or -1 per sign before saturation.
- FIFO: C_RD_LAT+3 entries, first-word-fall-through, O_dout is a register. Its depth together with the issue rule guarantees no overflow under any I_rdy pattern.
- I_start while busy has no effect. I_len/I_bias/I_shift changes after start have no effect.
- Reset at any time clears the FSM to IDLE, counters and FIFO pointers to 0, and all valids to 0.
- Reset values: O_raddr=0, O_dout=0, O_dv=0, O_busy=0, O_done=0.

## Timing
- I_start at cycle 0: RUN and O_busy=1 at cycle 1, O_raddr=0 at cycle 1.
- I_rdata for address 0 is sampled at cycle 1+C_RD_LAT.
- First O_dv=1 at cycle C_RD_LAT+4 (7 by default).
- With I_rdy held high: one result per cycle, no bubbles.
  - Last transfer at cycle C_RD_LAT+3+len.
  - O_done at the following cycle; O_busy drops with O_done.
- With I_rdy low: O_dout/O_dv hold stable until the transfer completes.
  - Issue stalls once C_RD_LAT+3 words are outstanding or buffered.
- Back-to-back operation: I_start is accepted in the cycle after DONE (IDLE).

## Configuration
- SUM_DRAIN_RELU_EN defined: after the shift, negative y is forced to 0 before saturation. Output range is 0..2^(C_OSIZE-1)-1.
- Not defined: full signed saturation as above.
- Latency and handshake are identical in both builds.

## Test plan
- Basic sweep: len=4, bias=0, shift=0, RAM data {5,-3,127,-128}, I_rdy=1 -> O_dout 5,-3,127,-128 at cycles 7..10; O_done at 11.
- Round/saturate: bias=100, shift=4, data {0x000008, 0x7FFFFF, 0xFFF000} -> 7, 127, -128.
  - With SUM_DRAIN_RELU_EN: 7, 127, 0.
- Back-pressure: len=16, I_rdy random 30% high -> all 16 words in order, none duplicated or lost.
  - O_dout stable while O_dv && !I_rdy.
  - O_raddr never exceeds outstanding+buffered 6.
- len=0 -> O_done at cycle 1, O_dv never asserts, O_raddr stays 0.
- Full range: len=1024 -> O_raddr wraps 1023 -> 0 only after the final issue, exactly 1024 transfers.
  - A second I_start mid-run is ignored.
- Reset mid-run: deassert I_rst_n at the 10th transfer -> all outputs 0 immediately.
  - A new start after reset replays from address 0.
